// File: rtl/mips_cpu_bus_master.sv
// mips_cpu_bus_master: CPU memory-stage initiator on a 32-bit word bus.
// Accepts one load/store at a time, issues an aligned read/write with byte
// enables, holds the command through waitrequest and returns extended load data.
module mips_cpu_bus_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_DATA = 3'd2,
        WR_CMD  = 3'd3,
        RESP    = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [1:0]  off_q;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = off[0];
            OP_LW, OP_SW:         bad = (off != 2'b00);
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return (op < OP_SB);
    endfunction

    // Little-endian lane selection: byte offset k drives byteenable[k].
    function automatic logic [3:0] lane_enable(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] be;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << off;
            OP_LH, OP_LHU, OP_SH: be = off[1] ? 4'b1100 : 4'b0011;
            default:              be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the store data into every lane avoids an offset-dependent shifter;
    // the byte enables pick out the lanes that matter.
    function automatic logic [31:0] lane_replicate(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        case (op)
            OP_SB:   r = {4{wd[7:0]}};
            OP_SH:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pull the addressed lane(s) out of the bus word and sign/zero extend.
    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] data);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = data >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? data[31:16] : data[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = data;
        endcase
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic for the single outstanding transaction.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_op, req_addr[1:0])) state_nxt = ERR;
                    else if (is_load(req_op))                 state_nxt = RD_CMD;
                    else                                      state_nxt = WR_CMD;
                end
            end
            RD_CMD:  if (!waitrequest) state_nxt = RD_DATA;
            RD_DATA: state_nxt = RESP;
            WR_CMD:  if (!waitrequest) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture at acceptance and result capture on the way into RESP/ERR;
    // resp_rdata only changes at the edge that starts a response, so it holds between them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= 3'd0;
            off_q      <= 2'd0;
            address    <= 32'd0;
            byteenable <= 4'd0;
            writedata  <= 32'd0;
            resp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (is_misaligned(req_op, req_addr[1:0])) begin
                            resp_rdata <= 32'd0;
                        end else begin
                            op_q       <= req_op;
                            off_q      <= req_addr[1:0];
                            address    <= {req_addr[31:2], 2'b00};
                            byteenable <= lane_enable(req_op, req_addr[1:0]);
                            writedata  <= lane_replicate(req_op, req_wdata);
                        end
                    end
                end
                RD_DATA: resp_rdata <= load_extend(op_q, off_q, readdata);
                WR_CMD:  if (!waitrequest) resp_rdata <= 32'd0;
                default: ;
            endcase
        end
    end

    // Handshake and command strobes decode straight from the state register.
    assign req_ready  = (state == IDLE);
    assign read       = (state == RD_CMD);
    assign write      = (state == WR_CMD);
    assign resp_valid = (state == RESP) || (state == ERR);
    assign resp_err   = (state == ERR);

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Directed bench for mips_cpu_bus_master with a small word RAM for the
// store-then-load sequence.
module tb_mips_cpu_bus_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    logic [31:0] tb_rdata;
    logic [31:0] ram_rdata;
    logic        ram_en;
    logic [31:0] mem [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    mips_cpu_bus_master dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    assign readdata = ram_en ? ram_rdata : tb_rdata;

    // Word RAM responder with fixed read latency of one cycle.
    always @(posedge clk) begin
        if (write && !waitrequest) mem[address[5:2]] <= writedata;
        if (read && !waitrequest)  ram_rdata <= mem[address[5:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    // Zero-wait load: command in cycle 1, RD_DATA in cycle 2, response in cycle 3.
    task automatic load_check(input string tag, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] exp);
        issue(op, addr, 32'h0);
        step();
        req_valid = 1'b0;
        check({tag, "_read"}, {31'd0, read}, 32'd1);
        step();
        step();
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_rdata"}, resp_rdata, exp);
        step();
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_op      = 3'd0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        waitrequest = 1'b0;
        tb_rdata    = 32'h0;
        ram_en      = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        ram_rdata   = 32'h0;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rw", {30'd0, read, write}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // SB to 0x1003, no stall
        issue(3'd5, 32'h0000_1003, 32'h0000_00AB);
        step();
        req_valid = 1'b0;
        check("sb_write", {31'd0, write}, 32'd1);
        check("sb_read", {31'd0, read}, 32'd0);
        check("sb_addr", address, 32'h0000_1000);
        check("sb_be", {28'd0, byteenable}, 32'h8);
        check("sb_wdata", writedata, 32'hABAB_ABAB);
        check("sb_ready", {31'd0, req_ready}, 32'd0);
        step();
        check("sb_resp", {31'd0, resp_valid}, 32'd1);
        check("sb_err", {31'd0, resp_err}, 32'd0);
        check("sb_rdata", resp_rdata, 32'h0);
        check("sb_wr_drop", {31'd0, write}, 32'd0);
        step();
        check("sb_resp_1cyc", {31'd0, resp_valid}, 32'd0);
        check("sb_ready_back", {31'd0, req_ready}, 32'd1);

        // LH from 0x2002 with three stall cycles
        waitrequest = 1'b1;
        issue(3'd2, 32'h0000_2002, 32'h0);
        step();
        req_valid = 1'b0;
        req_addr  = 32'h0000_5555;
        for (int c = 0; c < 3; c++) begin
            check("lh_read_held", {31'd0, read}, 32'd1);
            check("lh_addr", address, 32'h0000_2000);
            check("lh_be", {28'd0, byteenable}, 32'hC);
            step();
        end
        check("lh_read_c4", {31'd0, read}, 32'd1);
        check("lh_no_resp", {31'd0, resp_valid}, 32'd0);
        waitrequest = 1'b0;
        tb_rdata    = 32'h8001_1234;
        step();
        check("lh_read_drop", {31'd0, read}, 32'd0);
        step();
        check("lh_valid", {31'd0, resp_valid}, 32'd1);
        check("lh_rdata", resp_rdata, 32'hFFFF_8001);
        step();
        check("lh_rdata_hold", resp_rdata, 32'hFFFF_8001);
        load_check("lhu", 3'd3, 32'h0000_2002, 32'h0000_8001);

        // byte loads on every lane
        tb_rdata = 32'h807F_01FE;
        load_check("lb0", 3'd0, 32'h0000_3000, 32'hFFFF_FFFE);
        load_check("lb1", 3'd0, 32'h0000_3001, 32'h0000_0001);
        load_check("lb2", 3'd0, 32'h0000_3002, 32'h0000_007F);
        load_check("lb3", 3'd0, 32'h0000_3003, 32'hFFFF_FF80);
        load_check("lbu3", 3'd1, 32'h0000_3003, 32'h0000_0080);
        load_check("lw0", 3'd4, 32'h0000_0000, 32'h807F_01FE);

        // misaligned LW and SH
        issue(3'd4, 32'h0000_1002, 32'h0);
        step();
        req_valid = 1'b0;
        check("lw_mis_valid", {31'd0, resp_valid}, 32'd1);
        check("lw_mis_err", {31'd0, resp_err}, 32'd1);
        check("lw_mis_rdata", resp_rdata, 32'h0);
        check("lw_mis_rw", {30'd0, read, write}, 32'd0);
        step();
        check("lw_mis_rw2", {30'd0, read, write}, 32'd0);
        check("lw_mis_done", {31'd0, resp_valid}, 32'd0);
        issue(3'd6, 32'h0000_1001, 32'h1234);
        step();
        req_valid = 1'b0;
        check("sh_mis_valid", {31'd0, resp_valid}, 32'd1);
        check("sh_mis_err", {31'd0, resp_err}, 32'd1);
        check("sh_mis_rw", {30'd0, read, write}, 32'd0);
        step();
        check("sh_mis_rw2", {30'd0, read, write}, 32'd0);

        // SW then LW through the RAM; request fields change during the SW
        ram_en = 1'b1;
        issue(3'd7, 32'h0000_0010, 32'hDEAD_BEEF);
        step();
        req_addr  = 32'h0000_0044;
        req_wdata = 32'h1111_2222;
        check("sw_write", {31'd0, write}, 32'd1);
        check("sw_addr", address, 32'h0000_0010);
        check("sw_be", {28'd0, byteenable}, 32'hF);
        check("sw_wdata", writedata, 32'hDEAD_BEEF);
        step();
        check("sw_resp", {31'd0, resp_valid}, 32'd1);
        check("sw_addr_iso", address, 32'h0000_0010);
        req_op   = 3'd4;
        req_addr = 32'h0000_0010;
        step();
        check("b2b_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check("lw_read", {31'd0, read}, 32'd1);
        check("lw_addr", address, 32'h0000_0010);
        step();
        step();
        check("lw_valid", {31'd0, resp_valid}, 32'd1);
        check("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
        step();

        // asynchronous reset in the middle of RD_CMD
        waitrequest = 1'b1;
        issue(3'd4, 32'h0000_0030, 32'h0);
        step();
        req_valid = 1'b0;
        check("mid_read", {31'd0, read}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, req_ready}, 32'd1);
        check("arst_read", {31'd0, read}, 32'd0);
        check("arst_addr", address, 32'h0);
        check("arst_be", {28'd0, byteenable}, 32'h0);
        check("arst_wdata", writedata, 32'h0);
        check("arst_rdata", resp_rdata, 32'h0);
        check("arst_valid", {30'd0, resp_valid, resp_err}, 32'd0);
        reset_n     = 1'b1;
        waitrequest = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("arst_no_resp", {31'd0, resp_valid}, 32'd0);
            check("arst_idle_rw", {30'd0, read, write}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_master.md
# mips_cpu_bus_master

Initiator end of the CPU's 32-bit memory bus: takes one load/store request at a time from the CPU datapath, turns it into a word-aligned bus read or write with byte enables, and holds the command through `waitrequest` stalls. For loads it returns the extracted, sign- or zero-extended result. It sits between the CPU's memory stage and the RAM/peripheral responder.

## Interface
- Parameters: none.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: block is idle and accepts a request this cycle.
- `req_op` in 3: operation.
  - 0 = LB, 1 = LBU, 2 = LH, 3 = LHU, 4 = LW, 5 = SB, 6 = SH, 7 = SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: misaligned access; qualified by `resp_valid`.
- `resp_rdata` out 32: load result, extended; 0 for stores and errors.
- `address` out 32: bus byte address with bits [1:0] = 0.
- `read` out 1: bus read command.
- `write` out 1: bus write command.
- `waitrequest` in 1: responder stall.
- `writedata` out 32: lane-positioned store data.
- `byteenable` out 4: active lanes.
- `readdata` in 32: bus read data.

## Operation
- Lane mapping is little-endian.
  - Byte offset k = `req_addr[1:0]` maps to `byteenable[k]` and data bits [8k+7:8k].
  - Halfword at offset 0 uses `byteenable` 0011; at offset 2 it uses 1100.
  - Word uses 1111.
- Misaligned access:
  - Halfword with `req_addr[0]`=1, or word with `req_addr[1:0]`≠0.
  - No bus command is issued; the request responds with `resp_err`=1.
- Stores: `writedata` = `req_wdata` replicated into every lane. SB replicates `req_wdata[7:0]` ×4; SH replicates `req_wdata[15:0]` ×2; SW uses it unchanged. Only enabled lanes are meaningful.
- Loads:
  - Select the addressed lane(s) of the captured `readdata`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed unchanged.
- All request fields are registered at acceptance; later changes to `req_*` have no effect.
- State machine:
  - IDLE: `req_ready`=1. On `req_valid`, go to ERR if misaligned, else RD_CMD (loads) or WR_CMD (stores).
  - RD_CMD: `read`=1. On `waitrequest`=0, go to RD_DATA.
  - RD_DATA: capture `readdata`; go to RESP.
  - WR_CMD: `write`=1. On `waitrequest`=0, go to RESP.
  - RESP: `resp_valid`=1, `resp_err`=0; go to IDLE.
  - ERR: `resp_valid`=1, `resp_err`=1; go to IDLE.
- Address 0 gets no special treatment: a LW at 0 issues a normal bus read.

## Timing
- Reset (asynchronous, immediate), every output goes to 0 except `req_ready`=1:
  - state = IDLE.
  - `read`=`write`=0, `address`=0, `writedata`=0, `byteenable`=0.
  - `resp_valid`=`resp_err`=0, `resp_rdata`=0.
- Reset mid-transaction abandons it; no response is ever produced for it.
- All outputs are registered or decoded from the registered state. No combinational path from `waitrequest` or `readdata` to any output.
- Acceptance happens at the rising edge where `req_valid`=1 in IDLE. Call that cycle 0.
- Bus command appears in cycle 1.
  - `address`, `byteenable`, `writedata` and `read`/`write` stay stable while `waitrequest`=1.
  - The command drops the cycle after the edge at which `waitrequest`=0.
- Read data is valid on `readdata` in the cycle after the command is accepted (fixed latency 1). It is sampled in RD_DATA regardless of `waitrequest`.
- Zero-wait latency, acceptance to `resp_valid`:
  - store: 2 cycles.
  - load: 3 cycles.
  - error: 1 cycle.
  - Each `waitrequest` cycle adds one.
- `read` and `write` are never both 1. At most one transaction is outstanding.
- `req_ready`=0 from cycle 1 until the cycle after RESP/ERR. Back-to-back requests are therefore spaced ≥3 cycles for stores and ≥4 for loads.
- `resp_rdata` is held until the next response. `resp_valid` is exactly one cycle wide.

## Test plan
- **Reset state:** assert `reset_n`=0 mid-RD_CMD, with no clock edge → all outputs 0 and `req_ready`=1 immediately; no `resp_valid` after release.
- **SB, no stall:** SB to addr 0x1003 with wdata 0x000000AB, `waitrequest`=0.
  - Cycle 1: `write`=1, `address`=0x1000, `byteenable`=1000, `writedata`=0xABABABAB.
  - Cycle 2: `resp_valid`=1.
- **LH sign-extend, 3-cycle stall:** LH from 0x2002, `waitrequest`=1 for 3 cycles, `readdata`=0x8001_1234.
  - `read` held 4 cycles with `address`=0x2000, `byteenable`=1100.
  - `resp_rdata`=0xFFFF8001. LHU of the same data returns 0x00008001.
- **LB/LBU all lanes:** `readdata`=0x80_7F_01_FE at offsets 0..3.
  - LB returns 0xFFFFFFFE, 0x00000001, 0x0000007F, 0xFFFFFF80.
  - LBU at offset 3 returns 0x00000080.
- **Misaligned:** LW at 0x1002 and SH at 0x1001 → `resp_valid`=1 and `resp_err`=1 in cycle 1; `read`/`write` never asserted.
- **Back-to-back plus input isolation:** SW 0xDEADBEEF to 0x10 immediately followed by LW from 0x10 (RAM model).
  - `resp_rdata`=0xDEADBEEF.
  - Changing `req_addr` during the SW has no effect on the bus.
